udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
//  Shares one UDP transmit engine between two packet sources on eth_tx_clk.
//  ch0 is the video packetizer; ch1 is a command/status responder.
//  Latches each source's single-cycle start request and grants whole packets round-robin.
//  Routes req/data/done between the engine and the granted source, with an inter-packet gap
//  and a done-timeout watchdog.
// PARAMETERS
//  IFG_CYC      16'd12      idle cycles between packets (GAP state); 0 = no gap
//  TIMEOUT_CYC  24'd2000000 max cycles waiting for udp_tx_done before forced release
// PORTS
//  eth_tx_clk       in   1   sole clock
//  rst_n            in   1   asynchronous reset, active-low
//  arb_en           in   1   1 = grant packets; 0 = flush pending, no new grants
//  chN_tx_start_en  in   1   N=0,1; one-cycle packet request
//  chN_tx_byte_num  in   16  N=0,1; packet length in bytes, sampled with start_en
//  chN_tx_data      in   32  N=0,1; source data (source FIFO rd_data)
//  chN_tx_req       out  1   N=0,1; engine read strobe routed to the owner
//  chN_tx_done      out  1   N=0,1; engine done routed to the owner
//  chN_tx_drop      out  1   N=0,1; one-cycle pulse: request discarded
//  udp_tx_start_en  out  1   one-cycle start to the UDP engine
//  udp_tx_byte_num  out  16  length of the packet in flight
//  udp_tx_data      out  32  data muxed from the owner
//  udp_tx_req       in   1   engine read strobe
//  udp_tx_done      in   1   engine packet-complete pulse
//  grant_ch         out  1   current/last owner
//  busy             out  1   1 in any state except IDLE
//  timeout_err      out  1   one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset values: all outputs 0, except grant_ch=1 (ch0 wins the first tie). State is IDLE.
//  Pending latch per channel:
//   - start_en with arb_en=1 and pend=0 sets pend and captures byte_num.
//   - Discard with drop pulse when start_en arrives while that channel is pending or owns
//     the engine, when byte_num==0, or when arb_en=0.
//   - pend clears on the cycle its channel is granted.
//  FSM:
//   - IDLE: if arb_en and any pend, choose the owner.
//     - Both pending: owner = ~grant_ch. Otherwise the pending channel.
//     - Register grant_ch, udp_tx_byte_num=latched length, udp_tx_start_en=1; go START.
//   - START (1 cycle): start_en drops to 0; go WAIT_DONE. Watchdog is cleared.
//   - WAIT_DONE: watchdog counts each cycle.
//     - On udp_tx_done: go GAP.
//     - On count==TIMEOUT_CYC-1: pulse timeout_err, go GAP.
//   - GAP: count IFG_CYC cycles, then go IDLE. IFG_CYC=0 goes IDLE next cycle.
//  Latency: start_en at edge k -> pend at k -> udp_tx_start_en high in the cycle after edge k+1.
//  Routing is combinational on the registered grant_ch.
//   - udp_tx_data mirrors the owner's chN_tx_data, so zero added read latency.
//   - chN_tx_req = udp_tx_req & (grant_ch==N) & (state==START|WAIT_DONE).
//   - chN_tx_done = udp_tx_done & (grant_ch==N) & (state==WAIT_DONE). A stray done
//     in any other state is ignored.
//  arb_en falling: clears both pends at once; an in-flight packet runs to done/timeout.
//  Simultaneous udp_tx_done and watchdog expiry: done wins, no timeout_err.
//  Same-cycle start_en from both channels: both latched; tie broken per grant_ch.
//  Async reset mid-packet: immediate IDLE. No done is emitted to sources.
// STRUCTURE
//  udp_arb_pkg: state encoding (IDLE/START/WAIT_DONE/GAP, 2-bit), channel IDs CH_VIDEO=0/CH_CMD=1.
//  Sub-module udp_arb_req_latch, instantiated per channel: pend flag, byte_num
//  capture, drop logic.
//  Top holds the FSM, round-robin pointer, gap/watchdog counter and the muxes.
// TESTING
//  1. ch0 start, byte_num=16'd2568 -> udp_tx_start_en 2 cycles later, byte_num=2568; done routes to ch0 only.
//  2. ch0+ch1 start same cycle after reset -> ch0 served first, ch1 after done + 12-cycle gap.
//  3. ch1 start while ch1 owns the engine -> ch1_tx_drop pulse; no second ch1 packet.
//  4. ch0 start with byte_num=0 -> ch0_tx_drop pulse; state stays IDLE.
//  5. No done, TIMEOUT_CYC=100 -> timeout_err exactly 100 cycles after START exits; then IDLE after the gap.
//  6. arb_en=0 with ch1 pending and ch0 in flight -> ch0 completes; ch1 never started.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared types for the two-source UDP transmit arbiter.
// State encoding, channel ids and the round-robin pick.
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  localparam logic CH_VIDEO = 1'b0;
  localparam logic CH_CMD   = 1'b1;

  localparam int CNT_W = 24;

  // Both pending: alternate away from the last owner.
  function automatic logic rr_pick(
    input logic p0,
    input logic p1,
    input logic last
  );
    return (p0 & p1) ? ~last : p1;
  endfunction

endpackage

// File: rtl/udp_arb_req_latch.sv
// Per-channel start-request latch for the UDP arbiter.
// Holds one pending packet length and flags discarded requests.
module udp_arb_req_latch
  import udp_arb_pkg::*;
(
  input  logic        eth_tx_clk,
  input  logic        rst_n,
  input  logic        arb_en,
  input  logic        start_en,
  input  logic [15:0] byte_num,
  input  logic        owns,
  input  logic        grant,
  output logic        pend,
  output logic [15:0] len,
  output logic        drop
);

  logic bad;

  assign bad = ~arb_en | pend | owns
             | (byte_num == 16'd0);

  // Capture accepted requests, clear on grant or disable.
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      len  <= 16'd0;
      drop <= 1'b0;
    end else begin
      drop <= start_en & bad;
      if (!arb_en || grant) begin
        pend <= 1'b0;
      end else if (start_en && !bad) begin
        pend <= 1'b1;
        len  <= byte_num;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP tx engine between two sources.
// Whole-packet grants, inter-packet gap and done watchdog.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter logic [15:0] IFG_CYC     = 16'd12,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
  input  logic        eth_tx_clk,
  input  logic        rst_n,
  input  logic        arb_en,
  input  logic        ch0_tx_start_en,
  input  logic [15:0] ch0_tx_byte_num,
  input  logic [31:0] ch0_tx_data,
  output logic        ch0_tx_req,
  output logic        ch0_tx_done,
  output logic        ch0_tx_drop,
  input  logic        ch1_tx_start_en,
  input  logic [15:0] ch1_tx_byte_num,
  input  logic [31:0] ch1_tx_data,
  output logic        ch1_tx_req,
  output logic        ch1_tx_done,
  output logic        ch1_tx_drop,
  output logic        udp_tx_start_en,
  output logic [15:0] udp_tx_byte_num,
  output logic [31:0] udp_tx_data,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        grant_ch,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] TO_LAST =
    TIMEOUT_CYC - 24'd1;
  localparam logic [CNT_W-1:0] IFG_LAST =
    (IFG_CYC == 16'd0) ? 24'd0
                       : {8'd0, IFG_CYC - 16'd1};

  arb_state_t       state;
  arb_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic             pend0;
  logic             pend1;
  logic [15:0]      len0;
  logic [15:0]      len1;
  logic             active;
  logic             go;
  logic             pick;
  logic             to_hit;

  assign active = (state == ST_START)
                | (state == ST_WAIT);
  assign go     = (state == ST_IDLE) & arb_en
                & (pend0 | pend1);
  assign pick   = rr_pick(pend0, pend1, grant_ch);
  assign to_hit = (state == ST_WAIT)
                & (cnt == TO_LAST);

  udp_arb_req_latch u_lat0 (
    .eth_tx_clk (eth_tx_clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .start_en   (ch0_tx_start_en),
    .byte_num   (ch0_tx_byte_num),
    .owns       (active & (grant_ch == CH_VIDEO)),
    .grant      (go & (pick == CH_VIDEO)),
    .pend       (pend0),
    .len        (len0),
    .drop       (ch0_tx_drop)
  );

  udp_arb_req_latch u_lat1 (
    .eth_tx_clk (eth_tx_clk),
    .rst_n      (rst_n),
    .arb_en     (arb_en),
    .start_en   (ch1_tx_start_en),
    .byte_num   (ch1_tx_byte_num),
    .owns       (active & (grant_ch == CH_CMD)),
    .grant      (go & (pick == CH_CMD)),
    .pend       (pend1),
    .len        (len1),
    .drop       (ch1_tx_drop)
  );

  // State register plus owner/length capture on grant.
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      grant_ch        <= CH_CMD;
      udp_tx_byte_num <= 16'd0;
    end else begin
      state <= state_n;
      if (go) begin
        grant_ch        <= pick;
        udp_tx_byte_num <= pick ? len1 : len0;
      end
    end
  end

  // Gap/watchdog counter restarts on every state change.
  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_n != state
                 || state == ST_IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (go) state_n = ST_START;
      ST_START: state_n = ST_WAIT;
      ST_WAIT:  if (udp_tx_done || to_hit)
                  state_n = ST_GAP;
      ST_GAP:   if (cnt == IFG_LAST)
                  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Engine start, status and owner routing.
  always_comb begin
    udp_tx_start_en = (state == ST_START);
    busy            = (state != ST_IDLE);
    timeout_err     = to_hit & ~udp_tx_done;
    ch0_tx_req  = udp_tx_req & active
                & (grant_ch == CH_VIDEO);
    ch1_tx_req  = udp_tx_req & active
                & (grant_ch == CH_CMD);
    ch0_tx_done = udp_tx_done & (state == ST_WAIT)
                & (grant_ch == CH_VIDEO);
    ch1_tx_done = udp_tx_done & (state == ST_WAIT)
                & (grant_ch == CH_CMD);
  end

  assign udp_tx_data = grant_ch ? ch1_tx_data
                                : ch0_tx_data;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter.
// Directed scenarios plus randomized traffic vs a packet-level model.
module tb_udp_tx_arbiter;

  logic        eth_tx_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b1;
  logic        ch0_tx_start_en = 1'b0;
  logic [15:0] ch0_tx_byte_num = 16'd0;
  logic [31:0] ch0_tx_data = 32'd0;
  logic        ch0_tx_req, ch0_tx_done, ch0_tx_drop;
  logic        ch1_tx_start_en = 1'b0;
  logic [15:0] ch1_tx_byte_num = 16'd0;
  logic [31:0] ch1_tx_data = 32'd0;
  logic        ch1_tx_req, ch1_tx_done, ch1_tx_drop;
  logic        udp_tx_start_en;
  logic [15:0] udp_tx_byte_num;
  logic [31:0] udp_tx_data;
  logic        udp_tx_req = 1'b0;
  logic        udp_tx_done = 1'b0;
  logic        grant_ch, busy, timeout_err;

  int errs = 0;
  int checks = 0;

  always #5 eth_tx_clk = ~eth_tx_clk;

  udp_tx_arbiter #(
    .IFG_CYC     (16'd12),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .eth_tx_clk      (eth_tx_clk),
    .rst_n           (rst_n),
    .arb_en          (arb_en),
    .ch0_tx_start_en (ch0_tx_start_en),
    .ch0_tx_byte_num (ch0_tx_byte_num),
    .ch0_tx_data     (ch0_tx_data),
    .ch0_tx_req      (ch0_tx_req),
    .ch0_tx_done     (ch0_tx_done),
    .ch0_tx_drop     (ch0_tx_drop),
    .ch1_tx_start_en (ch1_tx_start_en),
    .ch1_tx_byte_num (ch1_tx_byte_num),
    .ch1_tx_data     (ch1_tx_data),
    .ch1_tx_req      (ch1_tx_req),
    .ch1_tx_done     (ch1_tx_done),
    .ch1_tx_drop     (ch1_tx_drop),
    .udp_tx_start_en (udp_tx_start_en),
    .udp_tx_byte_num (udp_tx_byte_num),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_done     (udp_tx_done),
    .grant_ch        (grant_ch),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  task automatic step();
    @(posedge eth_tx_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    arb_en = 1'b1;
    ch0_tx_start_en = 1'b0;
    ch1_tx_start_en = 1'b0;
    ch0_tx_byte_num = 16'd0;
    ch1_tx_byte_num = 16'd0;
    udp_tx_req = 1'b0;
    udp_tx_done = 1'b0;
    repeat (2) @(posedge eth_tx_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One-cycle start pulse on the selected channels.
  task automatic req(input bit e0, input bit e1,
                     input logic [15:0] l0,
                     input logic [15:0] l1);
    step();
    ch0_tx_start_en = e0;
    ch1_tx_start_en = e1;
    ch0_tx_byte_num = l0;
    ch1_tx_byte_num = l1;
    step();
    ch0_tx_start_en = 1'b0;
    ch1_tx_start_en = 1'b0;
  endtask

  // Bounded wait for udp_tx_start_en; n=-1 on expiry.
  task automatic wait_start(input int maxc,
                            output int n);
    bit hit;
    hit = 1'b0;
    n = -1;
    for (int i = 1; i <= maxc && !hit; i++) begin
      @(negedge eth_tx_clk);
      if (udp_tx_start_en) begin
        n = i;
        hit = 1'b1;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge eth_tx_clk);
    checks++;
    if ({grant_ch, busy, udp_tx_start_en, timeout_err,
         ch0_tx_drop, ch1_tx_drop, ch0_tx_done,
         ch1_tx_done} !== 8'b1000_0000) begin
      errs++;
      $display("FAIL reset_flags: got %b want 10000000",
        {grant_ch, busy, udp_tx_start_en, timeout_err,
         ch0_tx_drop, ch1_tx_drop, ch0_tx_done,
         ch1_tx_done});
    end
    checks++;
    if (udp_tx_byte_num !== 16'd0) begin
      errs++;
      $display("FAIL reset_len: got %0d want 0",
        udp_tx_byte_num);
    end
    do_reset();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    req(1, 0, 16'd2568, 16'd0);
    wait_start(10, n);
    checks++;
    if (n !== 2) begin
      errs++;
      $display("FAIL single_latency: got %0d want 2", n);
    end
    checks++;
    if (udp_tx_byte_num !== 16'd2568 || grant_ch !== 1'b0)
    begin
      errs++;
      $display("FAIL single_grant: got len %0d ch %0d want 2568 ch 0",
        udp_tx_byte_num, grant_ch);
    end
    step();
    udp_tx_req = 1'b1;
    @(negedge eth_tx_clk);
    checks++;
    if ({ch0_tx_req, ch1_tx_req, udp_tx_start_en}
        !== 3'b100) begin
      errs++;
      $display("FAIL single_req: got %b want 100",
        {ch0_tx_req, ch1_tx_req, udp_tx_start_en});
    end
    step();
    udp_tx_req = 1'b0;
    udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    checks++;
    if ({ch0_tx_done, ch1_tx_done} !== 2'b10) begin
      errs++;
      $display("FAIL single_done: got %b want 10",
        {ch0_tx_done, ch1_tx_done});
    end
    step();
    udp_tx_done = 1'b0;
  endtask

  task automatic test_both();
    int n;
    bit hit;
    do_reset();
    req(1, 1, 16'd100, 16'd200);
    wait_start(10, n);
    checks++;
    if (n !== 2 || grant_ch !== 1'b0
        || udp_tx_byte_num !== 16'd100) begin
      errs++;
      $display("FAIL both_first: got n %0d ch %0d len %0d want 2 0 100",
        n, grant_ch, udp_tx_byte_num);
    end
    step();
    step();
    udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    n = -1;
    hit = 1'b0;
    for (int i = 1; i <= 50 && !hit; i++) begin
      step();
      udp_tx_done = 1'b0;
      @(negedge eth_tx_clk);
      if (udp_tx_start_en) begin
        n = i;
        hit = 1'b1;
      end
    end
    checks++;
    if (n !== 14 || grant_ch !== 1'b1
        || udp_tx_byte_num !== 16'd200) begin
      errs++;
      $display("FAIL both_second: got n %0d ch %0d len %0d want 14 1 200",
        n, grant_ch, udp_tx_byte_num);
    end
    step();
    udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    step();
    udp_tx_done = 1'b0;
  endtask

  task automatic test_drop_owner();
    int n;
    do_reset();
    req(0, 1, 16'd0, 16'd100);
    wait_start(10, n);
    step();
    ch1_tx_start_en = 1'b1;
    ch1_tx_byte_num = 16'd77;
    @(negedge eth_tx_clk);
    step();
    ch1_tx_start_en = 1'b0;
    @(negedge eth_tx_clk);
    checks++;
    if (ch1_tx_drop !== 1'b1 || ch0_tx_drop !== 1'b0) begin
      errs++;
      $display("FAIL owner_drop: got %b want 10",
        {ch1_tx_drop, ch0_tx_drop});
    end
    step();
    @(negedge eth_tx_clk);
    checks++;
    if (ch1_tx_drop !== 1'b0) begin
      errs++;
      $display("FAIL owner_drop_width: got %0d want 0",
        ch1_tx_drop);
    end
    step();
    udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    checks++;
    if ({ch0_tx_done, ch1_tx_done} !== 2'b01) begin
      errs++;
      $display("FAIL owner_done: got %b want 01",
        {ch0_tx_done, ch1_tx_done});
    end
    step();
    udp_tx_done = 1'b0;
    wait_start(40, n);
    checks++;
    if (n !== -1) begin
      errs++;
      $display("FAIL owner_no_repeat: got start at %0d want none",
        n);
    end
  endtask

  task automatic test_zero_len();
    int n;
    do_reset();
    step();
    ch0_tx_start_en = 1'b1;
    ch0_tx_byte_num = 16'd0;
    @(negedge eth_tx_clk);
    step();
    ch0_tx_start_en = 1'b0;
    @(negedge eth_tx_clk);
    checks++;
    if (ch0_tx_drop !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_drop: got drop %0d busy %0d want 1 0",
        ch0_tx_drop, busy);
    end
    wait_start(10, n);
    checks++;
    if (n !== -1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_idle: got start %0d busy %0d want -1 0",
        n, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit hit;
    do_reset();
    req(1, 0, 16'd64, 16'd0);
    wait_start(10, n);
    n = -1;
    hit = 1'b0;
    for (int i = 1; i <= 300 && !hit; i++) begin
      step();
      @(negedge eth_tx_clk);
      if (timeout_err) begin
        n = i;
        hit = 1'b1;
      end
    end
    checks++;
    if (n !== 100) begin
      errs++;
      $display("FAIL timeout_cyc: got %0d want 100", n);
    end
    n = -1;
    hit = 1'b0;
    for (int i = 1; i <= 50 && !hit; i++) begin
      step();
      @(negedge eth_tx_clk);
      if (!busy) begin
        n = i;
        hit = 1'b1;
      end
    end
    checks++;
    if (n !== 13) begin
      errs++;
      $display("FAIL timeout_gap: got %0d want 13", n);
    end
    req(1, 0, 16'd32, 16'd0);
    wait_start(10, n);
    for (int i = 1; i <= 99; i++) step();
    step();
    udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    checks++;
    if ({timeout_err, ch0_tx_done} !== 2'b01) begin
      errs++;
      $display("FAIL done_vs_timeout: got %b want 01",
        {timeout_err, ch0_tx_done});
    end
    step();
    udp_tx_done = 1'b0;
  endtask

  task automatic test_arb_off();
    int n;
    do_reset();
    req(1, 0, 16'd300, 16'd0);
    wait_start(10, n);
    step();
    ch1_tx_start_en = 1'b1;
    ch1_tx_byte_num = 16'd50;
    @(negedge eth_tx_clk);
    step();
    ch1_tx_start_en = 1'b0;
    arb_en = 1'b0;
    @(negedge eth_tx_clk);
    checks++;
    if (ch1_tx_drop !== 1'b0) begin
      errs++;
      $display("FAIL arboff_accept: got drop %0d want 0",
        ch1_tx_drop);
    end
    step();
    ch1_tx_start_en = 1'b1;
    @(negedge eth_tx_clk);
    step();
    ch1_tx_start_en = 1'b0;
    @(negedge eth_tx_clk);
    checks++;
    if (ch1_tx_drop !== 1'b1) begin
      errs++;
      $display("FAIL arboff_drop: got %0d want 1",
        ch1_tx_drop);
    end
    step();
    udp_tx_done = 1'b1;
    @(negedge eth_tx_clk);
    checks++;
    if ({ch0_tx_done, ch1_tx_done} !== 2'b10) begin
      errs++;
      $display("FAIL arboff_done: got %b want 10",
        {ch0_tx_done, ch1_tx_done});
    end
    step();
    udp_tx_done = 1'b0;
    wait_start(40, n);
    checks++;
    if (n !== -1) begin
      errs++;
      $display("FAIL arboff_hold: got start %0d want none", n);
    end
    arb_en = 1'b1;
    wait_start(20, n);
    checks++;
    if (n !== -1) begin
      errs++;
      $display("FAIL arboff_flushed: got start %0d want none",
        n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    req(1, 0, 16'd500, 16'd0);
    wait_start(10, n);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, grant_ch, udp_tx_start_en} !== 3'b010
        || udp_tx_byte_num !== 16'd0) begin
      errs++;
      $display("FAIL reset_mid: got %b len %0d want 010 len 0",
        {busy, grant_ch, udp_tx_start_en},
        udp_tx_byte_num);
    end
    udp_tx_done = 1'b1;
    #1;
    checks++;
    if ({ch0_tx_done, ch1_tx_done} !== 2'b00) begin
      errs++;
      $display("FAIL reset_mid_done: got %b want 00",
        {ch0_tx_done, ch1_tx_done});
    end
    udp_tx_done = 1'b0;
    do_reset();
  endtask

  // Packet-level model: pending slots, last owner, gap timing.
  task automatic test_random(input int ncyc);
    bit          pend [2];
    logic [15:0] plen [2];
    bit          stg [2];
    logic [15:0] slen [2];
    bit          sdrop [2];
    bit          r [2];
    logic [15:0] rl [2];
    logic [31:0] d [2];
    int          inflight, last, wcnt, done_cyc, own;
    bit          e_start, dn, rq, eq, ed;
    do_reset();
    inflight = -1;
    last = 1;
    wcnt = 0;
    done_cyc = -100;
    for (int c = 0; c < 2; c++) begin
      pend[c] = 0; stg[c] = 0; sdrop[c] = 0;
      plen[c] = 0; slen[c] = 0;
    end
    for (int j = 0; j < ncyc; j++) begin
      step();
      e_start = (inflight < 0) && (pend[0] || pend[1])
                && (j >= done_cyc + 14);
      dn = 1'b0;
      if (inflight >= 0) begin
        if (wcnt == 0) dn = 1'b1;
        else wcnt--;
      end else if (!e_start
                   && $urandom_range(0, 15) == 0) begin
        dn = 1'b1;
      end
      rq = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 2; c++) begin
        r[c] = 1'b0;
        rl[c] = 16'($urandom_range(1, 9000));
        if (!pend[c] && !stg[c] && inflight != c
            && $urandom_range(0, 9) == 0) begin
          r[c] = 1'b1;
          if ($urandom_range(0, 7) == 0) rl[c] = 16'd0;
        end
        d[c] = $urandom;
      end
      ch0_tx_start_en = r[0];
      ch1_tx_start_en = r[1];
      ch0_tx_byte_num = rl[0];
      ch1_tx_byte_num = rl[1];
      ch0_tx_data = d[0];
      ch1_tx_data = d[1];
      udp_tx_req = rq;
      udp_tx_done = dn;
      @(negedge eth_tx_clk);
      checks++;
      if (udp_tx_start_en !== e_start) begin
        errs++;
        $display("FAIL rnd_start c%0d: got %0d want %0d",
          j, udp_tx_start_en, e_start);
      end
      if (e_start) begin
        own = (pend[0] && pend[1]) ? 1 - last
                                   : (pend[1] ? 1 : 0);
        checks++;
        if (grant_ch !== own[0]
            || udp_tx_byte_num !== plen[own]) begin
          errs++;
          $display("FAIL rnd_grant c%0d: got ch %0d len %0d want ch %0d len %0d",
            j, grant_ch, udp_tx_byte_num, own, plen[own]);
        end
        pend[own] = 0;
        last = own;
        inflight = own;
        wcnt = $urandom_range(0, 20);
      end
      for (int c = 0; c < 2; c++) begin
        eq = rq && (inflight == c);
        ed = dn && (inflight == c);
        checks++;
        if ((c == 0 ? ch0_tx_req : ch1_tx_req) !== eq
            || (c == 0 ? ch0_tx_done : ch1_tx_done) !== ed
            || (c == 0 ? ch0_tx_drop : ch1_tx_drop)
               !== sdrop[c]) begin
          errs++;
          $display("FAIL rnd_route c%0d ch%0d: got req %0d done %0d drop %0d want %0d %0d %0d",
            j, c,
            (c == 0 ? ch0_tx_req : ch1_tx_req),
            (c == 0 ? ch0_tx_done : ch1_tx_done),
            (c == 0 ? ch0_tx_drop : ch1_tx_drop),
            eq, ed, sdrop[c]);
        end
      end
      checks++;
      if (udp_tx_data !== d[last]) begin
        errs++;
        $display("FAIL rnd_data c%0d: got %h want %h",
          j, udp_tx_data, d[last]);
      end
      if (dn && inflight >= 0) begin
        inflight = -1;
        done_cyc = j;
      end
      for (int c = 0; c < 2; c++) begin
        if (stg[c]) begin
          pend[c] = 1;
          plen[c] = slen[c];
        end
        stg[c] = 0;
        sdrop[c] = 0;
        if (r[c]) begin
          if (rl[c] == 16'd0) sdrop[c] = 1;
          else begin
            stg[c] = 1;
            slen[c] = rl[c];
          end
        end
      end
    end
    step();
    ch0_tx_start_en = 1'b0;
    ch1_tx_start_en = 1'b0;
    udp_tx_req = 1'b0;
    udp_tx_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_drop_owner();
    test_zero_len();
    test_timeout();
    test_arb_off();
    test_reset_mid();
    test_random(4000);
    $display("Result: errors=%0d of %0d checks",
      errs, checks);
    $finish;
  end

endmodule
